// File: rtl/multi_spinner.sv
// N-channel spinner/dial emulator: digital buttons and HPS analog deltas drive WIDTH-bit wrapping positions.
// Optional quadrature outputs are built when SPINNER_QUAD_EN is defined.
module multi_spinner #(
  parameter int unsigned NCH       = 2,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned STEP_SLOW = 4,
  parameter int unsigned STEP_FAST = 12,
  parameter int unsigned ANA_SHIFT = 1,
  parameter int unsigned QDIV      = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 strobe,
  input  logic [NCH-1:0]       minus,
  input  logic [NCH-1:0]       plus,
  input  logic [NCH-1:0]       fast,
  input  logic [NCH*9-1:0]     spin_in,
  output logic [NCH*WIDTH-1:0] spin_out,
  output logic [NCH-1:0]       moved
`ifdef SPINNER_QUAD_EN
  ,
  output logic [NCH-1:0]       quad_a,
  output logic [NCH-1:0]       quad_b
`endif
);

  localparam int unsigned ACC_W = WIDTH + ANA_SHIFT;
  localparam logic [ACC_W-1:0] SLOW_INC = ACC_W'(STEP_SLOW) << ANA_SHIFT;
  localparam logic [ACC_W-1:0] FAST_INC = ACC_W'(STEP_FAST) << ANA_SHIFT;

  logic                        strobe_q;
  logic                        strobe_qq;
  logic                        armed;
  logic                        strobe_ev;
  logic [NCH-1:0]              tog_q;
  logic [NCH-1:0]              tog_qq;
  logic [NCH-1:0]              tog_ev;
  logic [NCH-1:0][7:0]         delta_q;
  logic [NCH-1:0][ACC_W-1:0]   acc;
  logic [NCH-1:0][ACC_W-1:0]   acc_nxt;
  logic [NCH-1:0][ACC_W-1:0]   dig;
  logic [NCH-1:0][ACC_W-1:0]   ana;

  // Event detection and the combined digital + analog accumulator update.
  always_comb begin
    strobe_ev = strobe_q & ~strobe_qq;
    tog_ev    = '0;
    dig       = '0;
    ana       = '0;
    acc_nxt   = acc;
    for (int c = 0; c < int'(NCH); c++) begin
      if (strobe_ev && (plus[c] ^ minus[c])) begin
        dig[c] = fast[c] ? FAST_INC : SLOW_INC;
        if (minus[c]) begin
          dig[c] = ACC_W'(0) - dig[c];
        end
      end
      tog_ev[c] = armed & (tog_q[c] ^ tog_qq[c]);
      if (tog_ev[c]) begin
        ana[c] = ACC_W'($signed(delta_q[c]));
      end
      acc_nxt[c] = acc[c] + dig[c] + ana[c];
    end
  end

  // Until armed, the toggle history tracks the live bit so a static level never reads as a change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      strobe_q  <= 1'b0;
      strobe_qq <= 1'b0;
      armed     <= 1'b0;
      tog_q     <= '0;
      tog_qq    <= '0;
      delta_q   <= '0;
      acc       <= '0;
      spin_out  <= '0;
      moved     <= '0;
    end else begin
      strobe_q  <= strobe;
      strobe_qq <= strobe_q;
      armed     <= 1'b1;
      for (int c = 0; c < int'(NCH); c++) begin
        tog_q[c]   <= spin_in[9*c+8];
        tog_qq[c]  <= armed ? tog_q[c] : spin_in[9*c+8];
        delta_q[c] <= spin_in[9*c +: 8];
        acc[c]     <= acc_nxt[c];
        spin_out[WIDTH*c +: WIDTH] <= acc[c][ACC_W-1:ANA_SHIFT];
        moved[c]   <= (acc[c][ACC_W-1:ANA_SHIFT] != spin_out[WIDTH*c +: WIDTH]);
      end
    end
  end

`ifdef SPINNER_QUAD_EN
  localparam int unsigned QCW = (QDIV > 1) ? $clog2(QDIV) : 1;
  localparam logic [WIDTH-1:0] HALF = WIDTH'(1) << (WIDTH - 1);

  logic [QCW-1:0]              qcnt;
  logic                        qtick;
  logic [NCH-1:0][WIDTH-1:0]   trk;
  logic [NCH-1:0][WIDTH-1:0]   trk_nxt;
  logic [NCH-1:0][WIDTH-1:0]   diff;

  // Tracker chases spin_out one unit per tick along the shorter way round; a tie goes up.
  always_comb begin
    qtick   = (qcnt == QCW'(QDIV - 1));
    trk_nxt = trk;
    diff    = '0;
    for (int c = 0; c < int'(NCH); c++) begin
      diff[c] = spin_out[WIDTH*c +: WIDTH] - trk[c];
      if (qtick && (diff[c] != '0)) begin
        trk_nxt[c] = (diff[c] <= HALF) ? trk[c] + WIDTH'(1) : trk[c] - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      qcnt   <= '0;
      trk    <= '0;
      quad_a <= '0;
      quad_b <= '0;
    end else begin
      qcnt <= qtick ? '0 : qcnt + QCW'(1);
      trk  <= trk_nxt;
      for (int c = 0; c < int'(NCH); c++) begin
        quad_a[c] <= trk_nxt[c][1];
        quad_b[c] <= trk_nxt[c][1] ^ trk_nxt[c][0];
      end
    end
  end
`endif

endmodule

// File: tb/tb_multi_spinner.sv
// Self-checking bench for multi_spinner (default build): directed test-plan cases plus randomized traffic vs. an arithmetic model.
module tb_multi_spinner;

  localparam int NCH   = 2;
  localparam int WIDTH = 8;
  localparam int ACC_M = 512;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               strobe = 1'b0;
  logic [NCH-1:0]     minus = '0;
  logic [NCH-1:0]     plus = '0;
  logic [NCH-1:0]     fast = '0;
  logic [NCH*9-1:0]   spin_in = '0;
  logic [NCH*WIDTH-1:0] spin_out;
  logic [NCH-1:0]     moved;

  logic [NCH-1:0]     tog = '0;
  logic [7:0]         dl [NCH];
  int                 exp_acc [NCH];
  int                 exp_mv [NCH];
  int                 mv_cnt [NCH];
  int                 checks = 0;
  int                 errors = 0;

  multi_spinner dut (
    .clk(clk), .reset(reset), .strobe(strobe), .minus(minus), .plus(plus),
    .fast(fast), .spin_in(spin_in), .spin_out(spin_out), .moved(moved)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    for (int c = 0; c < NCH; c++) if (moved[c]) mv_cnt[c]++;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  function automatic int pos(input int c);
    logic [WIDTH-1:0] v;
    v = spin_out[WIDTH*c +: WIDTH];
    return int'(v);
  endfunction

  task automatic pack_spin();
    for (int c = 0; c < NCH; c++) spin_in[9*c +: 9] = {tog[c], dl[c]};
  endtask

  // Reference: each channel is an integer modulo 2^(WIDTH+1); output is the upper WIDTH bits.
  task automatic model(input logic s, input logic [NCH-1:0] tg, input logic [NCH-1:0] p,
                       input logic [NCH-1:0] m, input logic [NCH-1:0] f);
    for (int c = 0; c < NCH; c++) begin
      int d = 0;
      int old = exp_acc[c];
      if (s && (p[c] != m[c])) d = (f[c] ? 12 : 4) * 2 * (p[c] ? 1 : -1);
      if (tg[c]) d += int'($signed(dl[c]));
      exp_acc[c] = (((old + d) % ACC_M) + ACC_M) % ACC_M;
      if ((old / 2) != (exp_acc[c] / 2)) exp_mv[c]++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset  = 1'b1;
    strobe = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < NCH; c++) exp_acc[c] = 0;
    repeat (2) @(negedge clk);
  endtask

  // One frame: optional strobe rise and/or toggles, buttons held steady throughout.
  task automatic xact(input logic s, input logic [NCH-1:0] tg, input logic [NCH-1:0] p,
                      input logic [NCH-1:0] m, input logic [NCH-1:0] f, input logic [7:0] d0,
                      input logic [7:0] d1, input logic chk);
    @(negedge clk);
    plus = p; minus = m; fast = f;
    if (tg[0]) begin dl[0] = d0; tog[0] = ~tog[0]; end
    if (tg[1]) begin dl[1] = d1; tog[1] = ~tog[1]; end
    pack_spin();
    strobe = s;
    model(s, tg, p, m, f);
    repeat (3) @(negedge clk);
    strobe = 1'b0;
    repeat (3) @(negedge clk);
    if (chk) for (int c = 0; c < NCH; c++) check($sformatf("pos%0d", c), pos(c), exp_acc[c] / 2);
  endtask

  initial begin
    int nz;
    dl[0] = 8'h00; dl[1] = 8'h00;
    for (int c = 0; c < NCH; c++) begin exp_acc[c] = 0; exp_mv[c] = 0; mv_cnt[c] = 0; end

    // Reset held with idle inputs and ch0 toggle bit static high.
    tog[0] = 1'b1;
    pack_spin();
    nz = 0;
    repeat (100) begin
      @(negedge clk);
      if (spin_out != '0 || moved != '0) nz++;
    end
    check("reset_hold", nz, 0);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("armed_pos", int'(spin_out), 0);
    check("armed_moved", mv_cnt[0] + mv_cnt[1], 0);

    // Latency: old value 1 and 2 clocks after sampling, new value with moved pulse after that.
    @(negedge clk);
    plus = 2'b01; strobe = 1'b1;
    model(1'b1, 2'b00, 2'b01, 2'b00, 2'b00);
    @(negedge clk);
    check("lat_s1", pos(0), 0);
    @(negedge clk);
    check("lat_s2", pos(0), 0);
    check("lat_mv2", int'(moved[0]), 0);
    @(negedge clk);
    check("lat_s3", pos(0), 4);
    check("lat_mv3", int'(moved[0]), 1);
    @(negedge clk);
    check("lat_mv4", int'(moved[0]), 0);
    strobe = 1'b0;
    repeat (3) @(negedge clk);
    xact(1'b1, 2'b00, 2'b01, 2'b00, 2'b00, 8'd0, 8'd0, 1'b0);
    xact(1'b1, 2'b00, 2'b01, 2'b00, 2'b00, 8'd0, 8'd0, 1'b0);
    check("plus3_ch0", pos(0), 12);
    check("plus3_ch1", pos(1), 0);
    check("plus3_mv", mv_cnt[0], 3);

    // Decrement with fast wraps below zero; both buttons held is a no-op.
    do_reset();
    xact(1'b1, 2'b00, 2'b00, 2'b01, 2'b01, 8'd0, 8'd0, 1'b0);
    check("wrap_ch0", pos(0), 244);
    nz = mv_cnt[0];
    for (int i = 0; i < 5; i++) xact(1'b1, 2'b00, 2'b01, 2'b01, 2'b00, 8'd0, 8'd0, 1'b0);
    check("both_ch0", pos(0), 244);
    check("both_mv", mv_cnt[0] - nz, 0);

    // Analog path on ch1, including fractional carry and negative extreme.
    do_reset();
    xact(1'b0, 2'b10, 2'b00, 2'b00, 2'b00, 8'd0, 8'd3, 1'b0);
    check("ana_3", pos(1), 1);
    xact(1'b0, 2'b10, 2'b00, 2'b00, 2'b00, 8'd0, 8'd3, 1'b0);
    check("ana_6", pos(1), 3);
    do_reset();
    xact(1'b0, 2'b10, 2'b00, 2'b00, 2'b00, 8'd0, 8'h80, 1'b0);
    check("ana_m128", pos(1), 192);
    do_reset();
    nz = mv_cnt[1];
    xact(1'b0, 2'b10, 2'b00, 2'b00, 2'b00, 8'd0, 8'd1, 1'b0);
    check("ana_frac", pos(1), 0);
    check("ana_frac_mv", mv_cnt[1] - nz, 0);

    // Digital and analog terms landing in the same clock.
    do_reset();
    xact(1'b1, 2'b01, 2'b01, 2'b00, 2'b00, 8'd2, 8'd0, 1'b0);
    check("same_clk", pos(0), 5);

    // Reset asserted before a pending update lands: nothing survives.
    do_reset();
    @(negedge clk);
    plus = 2'b01; strobe = 1'b1;
    @(negedge clk);
    reset = 1'b1; strobe = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    check("rst_stale", pos(0), 0);
    for (int c = 0; c < NCH; c++) exp_acc[c] = 0;

    // Randomized frames against the model.
    for (int c = 0; c < NCH; c++) begin exp_mv[c] = 0; end
    nz = mv_cnt[0];
    begin
      int base1;
      base1 = mv_cnt[1];
      for (int i = 0; i < 80; i++) begin
        xact(1'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom),
             8'($urandom), 8'($urandom), 1'b1);
      end
      check("rnd_mv0", mv_cnt[0] - nz, exp_mv[0]);
      check("rnd_mv1", mv_cnt[1] - base1, exp_mv[1]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
